// File: rtl/control_unit_if.sv
// Bundle of the control unit's handshake and datapath-facing signals.
// The slave modport belongs to the control unit. The master modport
// belongs to whatever drives it: the datapath/debug host or a testbench.
interface control_unit_if #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
);
   logic              start;
   logic              halt_req;
   logic              step;
   logic              resume;
   logic [5:0]        opcode;
   logic              z;
   logic [PC_W-1:0]   pc;
   logic [PC_W-1:0]   bp_addr;
   logic              bp_valid;
   logic              pc_en;
   logic              s_inc;
   logic              s_inm;
   logic              we3;
   logic              wez;
   logic [2:0]        op;
   logic              paused;
   logic              halted;
   logic [CNT_W-1:0]  instr_cnt;

   modport slave (
      input  start, halt_req, step, resume, opcode, z, pc, bp_addr, bp_valid,
      output pc_en, s_inc, s_inm, we3, wez, op, paused, halted, instr_cnt
   );

   modport master (
      output start, halt_req, step, resume, opcode, z, pc, bp_addr, bp_valid,
      input  pc_en, s_inc, s_inm, we3, wez, op, paused, halted, instr_cnt
   );
endinterface

// File: rtl/control_unit.sv
// Sequencing control unit for the single-cycle microcontroller datapath.
// It decodes the opcode and the Z flag into datapath controls. It runs an
// IDLE/RUN/PAUSE/STEP/HALT debug FSM and counts retired instructions with
// a saturating counter.
// Optional feature: define CONTROL_UNIT_BREAKPOINT_EN to enable the PC
// breakpoint and its bp_skip register.
module control_unit #(
   parameter int PC_W  = 10,
   parameter int CNT_W = 16
) (
   input  logic            clk,
   input  logic            reset,   // asynchronous, active low
   control_unit_if.slave   bus
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_RUN   = 3'd1;
   localparam logic [2:0] S_PAUSE = 3'd2;
   localparam logic [2:0] S_STEP  = 3'd3;
   localparam logic [2:0] S_HALT  = 3'd4;

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             legal;
   logic             bp_hit;
   logic             exec;

   // Legal opcodes are ALU (1xxxxx) or the 000xxx group (LI, jumps, NOP).
   assign legal = bus.opcode[5] | (bus.opcode[5:3] == 3'b000);

`ifdef CONTROL_UNIT_BREAKPOINT_EN
   logic bp_skip_q, bp_skip_d;

   assign bp_hit = (state_q == S_RUN) && bus.bp_valid &&
                   (bus.pc == bus.bp_addr) && !bp_skip_q;

   // The skip flag is armed when the FSM enters a breakpoint pause. No
   // instruction executes while paused, so arming it here behaves exactly
   // like arming it on resume/step. It lets the instruction at bp_addr
   // execute once, and clears on the next executing cycle.
   always_comb begin
      bp_skip_d = bp_skip_q;
      if (legal && bp_hit)
         bp_skip_d = 1'b1;
      else if (exec)
         bp_skip_d = 1'b0;
   end

   // Breakpoint skip flag register.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) bp_skip_q <= 1'b0;
      else        bp_skip_q <= bp_skip_d;
   end
`else
   assign bp_hit = 1'b0;
`endif

   // A cycle executes in RUN (unless a breakpoint fires) or in STEP.
   // An illegal opcode suppresses execution in both states.
   assign exec = (((state_q == S_RUN) && !bp_hit) || (state_q == S_STEP)) && legal;

   // Next-state logic. In RUN the priority is illegal > breakpoint > halt_req.
   // In PAUSE, resume wins over step.
   always_comb begin
      state_d = state_q;
      case (state_q)
         S_IDLE:  if (bus.start) state_d = S_RUN;
         S_RUN: begin
            if (!legal)            state_d = S_HALT;
            else if (bp_hit)       state_d = S_PAUSE;
            else if (bus.halt_req) state_d = S_PAUSE;
         end
         S_PAUSE: begin
            if (bus.resume)        state_d = S_RUN;
            else if (bus.step)     state_d = S_STEP;
         end
         S_STEP:  state_d = legal ? S_PAUSE : S_HALT;
         S_HALT:  state_d = S_HALT;
         default: state_d = S_IDLE;
      endcase
   end

   // The retired-instruction counter holds once it reaches all ones.
   always_comb begin
      cnt_d = cnt_q;
      if (exec && (cnt_q != {CNT_W{1'b1}}))
         cnt_d = cnt_q + CNT_ONE;
   end

   // State and counter registers.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
      end
   end

   // Datapath controls. While reset is asserted every output is forced to 0,
   // so writes drop the moment reset falls. Non-executing cycles select PC+1
   // and perform no writes.
   always_comb begin
      bus.pc_en = 1'b0;
      bus.s_inc = 1'b1;
      bus.s_inm = 1'b0;
      bus.we3   = 1'b0;
      bus.wez   = 1'b0;
      bus.op    = 3'b000;
      if (!reset) begin
         bus.s_inc = 1'b0;
      end else if (exec) begin
         bus.pc_en = 1'b1;
         if (bus.opcode[5]) begin
            bus.op  = bus.opcode[4:2];
            bus.we3 = 1'b1;
            bus.wez = 1'b1;
         end else if (!bus.opcode[2]) begin
            bus.we3   = 1'b1;
            bus.s_inm = 1'b1;
         end else begin
            case (bus.opcode[1:0])
               2'b00:   bus.s_inc = 1'b0;
               2'b01:   bus.s_inc = ~bus.z;
               2'b10:   bus.s_inc = bus.z;
               default: bus.s_inc = 1'b1;
            endcase
         end
      end
   end

   assign bus.paused    = reset && (state_q == S_PAUSE);
   assign bus.halted    = reset && (state_q == S_HALT);
   assign bus.instr_cnt = cnt_q;

endmodule

// File: tb/tb_control_unit.sv
// Scoreboard bench for control_unit (CNT_W=4 so saturation is reachable).
// Stimulus pushes the expected per-cycle outputs; a monitor pops and compares.
module tb_control_unit;

   typedef struct packed {
      logic       pc_en;
      logic       s_inc;
      logic       s_inm;
      logic       we3;
      logic       wez;
      logic [2:0] op;
      logic       paused;
      logic       halted;
      logic [3:0] cnt;
   } exp_t;

   logic clk;
   logic reset;
   exp_t  exp_q[$];
   string nm_q[$];
   int    n_cmp;
   int    n_bad;

   control_unit_if #(.PC_W(10), .CNT_W(4)) bus();

   control_unit #(.PC_W(10), .CNT_W(4)) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic exp_t mk(logic pe, logic si, logic sm, logic w3, logic wz,
                               logic [2:0] o, logic pa, logic ha, logic [3:0] c);
      exp_t e;
      e = {pe, si, sm, w3, wz, o, pa, ha, c};
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic expect_now(input string nm, input exp_t e);
      exp_q.push_back(e);
      nm_q.push_back(nm);
   endtask

   // Monitor: compare the outputs on the falling edge of every cycle that has an expectation.
   initial begin
      exp_t  act;
      exp_t  e;
      string nm;
      n_cmp = 0;
      n_bad = 0;
      forever begin
         @(negedge clk);
         if (exp_q.size() > 0) begin
            e  = exp_q.pop_front();
            nm = nm_q.pop_front();
            act = {bus.pc_en, bus.s_inc, bus.s_inm, bus.we3, bus.wez, bus.op,
                   bus.paused, bus.halted, bus.instr_cnt};
            n_cmp++;
            if (act !== e) begin
               n_bad++;
               $display("FAIL %s: actual pc_en,s_inc,s_inm,we3,wez,op,paused,halted,cnt=%b required %b",
                        nm, act, e);
            end
            $display("check %-10s outputs=%b", nm, act);
         end
      end
   end

   initial begin
      #100000;
      $display("FAIL timeout: simulation exceeded time limit");
      $fatal(1, "timeout");
   end

   localparam logic [5:0] OP_LI  = 6'b000000;
   localparam logic [5:0] OP_J   = 6'b000100;
   localparam logic [5:0] OP_JZ  = 6'b000101;
   localparam logic [5:0] OP_JNZ = 6'b000110;
   localparam logic [5:0] OP_NOP = 6'b000111;

   initial begin
      reset        = 1'b0;
      bus.start    = 1'b0;
      bus.halt_req = 1'b0;
      bus.step     = 1'b0;
      bus.resume   = 1'b0;
      bus.opcode   = OP_LI;
      bus.z        = 1'b0;
      bus.pc       = '0;
      bus.bp_addr  = 10'h3FF;
      bus.bp_valid = 1'b0;

      // Reset, then IDLE, then start.
      tick(); expect_now("reset", mk(0,0,0,0,0,3'b000,0,0,4'd0));
      tick(); reset = 1'b1;
              expect_now("idle", mk(0,1,0,0,0,3'b000,0,0,4'd0));
      tick(); bus.start = 1'b1;
              expect_now("idle_st", mk(0,1,0,0,0,3'b000,0,0,4'd0));
      // Decode in RUN.
      tick(); bus.opcode = OP_LI;
              expect_now("li", mk(1,1,1,1,0,3'b000,0,0,4'd0));
      tick(); bus.opcode = 6'b100100;
              expect_now("alu001", mk(1,1,0,1,1,3'b001,0,0,4'd1));
      tick(); bus.opcode = OP_JZ; bus.z = 1'b1;
              expect_now("jz_z1", mk(1,0,0,0,0,3'b000,0,0,4'd2));
      tick(); bus.z = 1'b0;
              expect_now("jz_z0", mk(1,1,0,0,0,3'b000,0,0,4'd3));
      tick(); bus.opcode = OP_J;
              expect_now("j", mk(1,0,0,0,0,3'b000,0,0,4'd4));
      tick(); bus.opcode = OP_JNZ; bus.z = 1'b1;
              expect_now("jnz_z1", mk(1,1,0,0,0,3'b000,0,0,4'd5));
      tick(); bus.opcode = 6'b111111;
              expect_now("alu111", mk(1,1,0,1,1,3'b111,0,0,4'd6));
      // halt_req: the current instruction retires, then PAUSE.
      tick(); bus.opcode = OP_NOP; bus.halt_req = 1'b1;
              expect_now("halt_req", mk(1,1,0,0,0,3'b000,0,0,4'd7));
      tick(); bus.halt_req = 1'b0;
              expect_now("pause", mk(0,1,0,0,0,3'b000,1,0,4'd8));
      tick(); bus.step = 1'b1;
              expect_now("step_req", mk(0,1,0,0,0,3'b000,1,0,4'd8));
      tick(); bus.step = 1'b0;
              expect_now("step_ex", mk(1,1,0,0,0,3'b000,0,0,4'd8));
      tick(); expect_now("pause2", mk(0,1,0,0,0,3'b000,1,0,4'd9));
      tick(); bus.resume = 1'b1; bus.step = 1'b1;
              expect_now("res_step", mk(0,1,0,0,0,3'b000,1,0,4'd9));
      tick(); bus.resume = 1'b0; bus.step = 1'b0;
              expect_now("run_a", mk(1,1,0,0,0,3'b000,0,0,4'd9));
      tick(); expect_now("run_b", mk(1,1,0,0,0,3'b000,0,0,4'd10));
      // Illegal opcode: the cycle is suppressed, then HALT ignores start/resume.
      tick(); bus.opcode = 6'b010000;
              expect_now("illegal", mk(0,1,0,0,0,3'b000,0,0,4'd11));
      tick(); bus.opcode = OP_LI; bus.resume = 1'b1;
              expect_now("halt_a", mk(0,1,0,0,0,3'b000,0,1,4'd11));
      tick(); expect_now("halt_b", mk(0,1,0,0,0,3'b000,0,1,4'd11));
      // Reset clears HALT; start is still high.
      tick(); reset = 1'b0; bus.resume = 1'b0;
              expect_now("reset2", mk(0,0,0,0,0,3'b000,0,0,4'd0));
      tick(); reset = 1'b1;
              expect_now("idle2", mk(0,1,0,0,0,3'b000,0,0,4'd0));
      // Saturation of the 4-bit counter.
      for (int i = 0; i < 20; i++) begin
         tick();
         expect_now("sat", mk(1,1,1,1,0,3'b000,0,0, (i >= 15) ? 4'd15 : 4'(i)));
      end
      tick(); expect_now("sat_hold", mk(1,1,1,1,0,3'b000,0,0,4'd15));

      // Breakpoint scenario.
      tick(); reset = 1'b0;
              expect_now("reset3", mk(0,0,0,0,0,3'b000,0,0,4'd0));
      tick(); reset = 1'b1; bus.opcode = OP_NOP; bus.pc = 10'd0;
              bus.bp_addr = 10'h003; bus.bp_valid = 1'b1;
              expect_now("idle3", mk(0,1,0,0,0,3'b000,0,0,4'd0));
      for (int i = 0; i < 3; i++) begin
         tick(); bus.pc = 10'(i);
         expect_now("bp_run", mk(1,1,0,0,0,3'b000,0,0,4'(i)));
      end
`ifdef CONTROL_UNIT_BREAKPOINT_EN
      tick(); bus.pc = 10'd3;
              expect_now("bp_fire", mk(0,1,0,0,0,3'b000,0,0,4'd3));
      tick(); expect_now("bp_pause", mk(0,1,0,0,0,3'b000,1,0,4'd3));
      tick(); bus.resume = 1'b1;
              expect_now("bp_resume", mk(0,1,0,0,0,3'b000,1,0,4'd3));
      tick(); bus.resume = 1'b0;
              expect_now("bp_skip", mk(1,1,0,0,0,3'b000,0,0,4'd3));
      tick(); bus.pc = 10'd4;
              expect_now("bp_after", mk(1,1,0,0,0,3'b000,0,0,4'd4));
      tick(); bus.pc = 10'd3;
              expect_now("bp_refire", mk(0,1,0,0,0,3'b000,0,0,4'd5));
      tick(); expect_now("bp_pause2", mk(0,1,0,0,0,3'b000,1,0,4'd5));
`else
      tick(); bus.pc = 10'd3;
              expect_now("bp_ignored", mk(1,1,0,0,0,3'b000,0,0,4'd3));
      tick(); bus.pc = 10'd4;
              expect_now("bp_run4", mk(1,1,0,0,0,3'b000,0,0,4'd4));
`endif

      // Let the monitor drain the queue. The wait is bounded.
      for (int i = 0; i < 5 && exp_q.size() > 0; i++) @(negedge clk);
      #1;
      if (exp_q.size() != 0) begin
         n_cmp++;
         n_bad++;
         $display("FAIL drain: actual %0d pending required 0", exp_q.size());
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
